// File: rtl/npu_pkg.sv
// Shared NPU definitions: ALU opcodes, issue FSM states and opcode legality check.
package npu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0011;
  localparam opcode_t OP_MUL = 4'b0101;
  localparam opcode_t OP_DIV = 4'b0111;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StHold
  } issue_state_e;

  function automatic logic is_legal_op(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/pe_instr_fifo.sv
// Synchronous instruction FIFO holding {opcode, a, b}; head is read combinationally.
module pe_instr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [4+2*WIDTH-1:0]       wdata,
  input  logic                       pop,
  output logic [4+2*WIDTH-1:0]       rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned DW = 4 + 2 * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO refuses pushes even when the head is leaving this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pe_issue_controller.sv
// Issue front-end for processing_element: buffers instructions, issues one at a time on
// registered PE inputs, captures result plus error flag and returns it over valid/ready.
module pe_issue_controller
  import npu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       pe_opcode,
  output logic [WIDTH-1:0] pe_a,
  output logic [WIDTH-1:0] pe_b,
  input  logic [WIDTH-1:0] pe_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_opcode,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned DW = 4 + 2 * WIDTH;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  issue_state_e     state_q;
  logic             ready_q;
  logic [3:0]       pe_opcode_q;
  logic [WIDTH-1:0] pe_a_q, pe_b_q;
  logic             out_valid_q, out_err_q;
  logic [WIDTH-1:0] out_result_q;
  logic [3:0]       out_opcode_q;

  logic [DW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push, pop;
  logic             cap_err;
  logic [WIDTH-1:0] cap_result;

  // ready_q keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty &&
                    ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign busy     = (fifo_count != '0) || (state_q != StIdle);

  assign pe_opcode  = pe_opcode_q;
  assign pe_a       = pe_a_q;
  assign pe_b       = pe_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_opcode = out_opcode_q;
  assign out_err    = out_err_q;

  pe_instr_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_opcode, in_a, in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Result qualification; divide-by-zero overrides whatever the PE produced.
  always_comb begin
    cap_err    = 1'b0;
    cap_result = pe_result;
    if (!is_legal_op(pe_opcode_q)) begin
      cap_err    = 1'b1;
      cap_result = '0;
    end else if ((pe_opcode_q == OP_DIV) && (pe_b_q == '0)) begin
      cap_err    = 1'b1;
      cap_result = '1;
    end
  end

  // Issue FSM with registered PE inputs and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      pe_opcode_q  <= '0;
      pe_a_q       <= '0;
      pe_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            {pe_opcode_q, pe_a_q, pe_b_q} <= fifo_rdata;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          out_result_q <= cap_result;
          out_opcode_q <= pe_opcode_q;
          out_err_q    <= cap_err;
          out_valid_q  <= 1'b1;
          state_q      <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (pop) begin
              {pe_opcode_q, pe_a_q, pe_b_q} <= fifo_rdata;
              state_q <= StIssue;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_issue_controller.sv
// Directed bench for pe_issue_controller with a behavioural processing_element model.
module tb_pe_issue_controller;
  import npu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a, in_b;
  logic [3:0]  pe_opcode;
  logic [15:0] pe_a, pe_b;
  logic [15:0] pe_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_opcode;
  logic        out_err;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_cyc    = 0;

  pe_issue_controller #(
    .WIDTH (16),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .pe_opcode  (pe_opcode),
    .pe_a       (pe_a),
    .pe_b       (pe_b),
    .pe_result  (pe_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Processing element model; divide-by-zero returns junk that must be ignored.
  always_comb begin
    pe_result = 16'hBEEF;
    case (pe_opcode)
      OP_ADD:  pe_result = pe_a + pe_b;
      OP_SUB:  pe_result = pe_a - pe_b;
      OP_MUL:  pe_result = pe_a * pe_b;
      OP_DIV:  pe_result = (pe_b == 16'h0) ? 16'h1234 : pe_a / pe_b;
      default: pe_result = 16'hBEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    step();
    in_valid  = 1'b0;
  endtask

  // Waits (bounded) for out_valid, checks the result, then lets the handshake edge pass.
  task automatic wait_result(input string tag, input logic [15:0] res, input logic [3:0] op,
                             input logic err, input bit check_gap);
    int n = 0;
    while ((out_valid !== 1'b1) && (n < 20)) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(out_result), 32'(res));
    chk({tag, "_opcode"}, 32'(out_opcode), 32'(op));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
    if (check_gap) chk({tag, "_gap"}, 32'(cyc - last_cyc), 32'd2);
    last_cyc = cyc;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 4'h0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pe_a", 32'(pe_a), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Single ADD: result visible after the second edge following acceptance.
    out_ready = 1'b1;
    push(OP_ADD, 16'h1234, 16'h5678);
    chk("add_lat_e0", 32'(out_valid), 32'd0);
    step();
    chk("add_lat_e1", 32'(out_valid), 32'd0);
    chk("add_pe_opcode", 32'(pe_opcode), 32'(OP_ADD));
    chk("add_pe_a", 32'(pe_a), 32'h1234);
    step();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", 32'(out_result), 32'h68AC);
    chk("add_opcode", 32'(out_opcode), 32'(OP_ADD));
    chk("add_err", 32'(out_err), 32'd0);
    step();
    chk("add_done_valid", 32'(out_valid), 32'd0);
    chk("add_done_busy", 32'(busy), 32'd0);

    // Back-to-back SUB/MUL/DIV at full throughput.
    push(OP_SUB, 16'h5678, 16'h1234);
    push(OP_MUL, 16'h1234, 16'h5678);
    push(OP_DIV, 16'h5678, 16'h1234);
    wait_result("sub", 16'h4444, OP_SUB, 1'b0, 1'b0);
    wait_result("mul", 16'h0060, OP_MUL, 1'b0, 1'b1);
    wait_result("div", 16'h0004, OP_DIV, 1'b0, 1'b1);

    // Error cases.
    push(OP_DIV, 16'h0010, 16'h0000);
    push(4'b0010, 16'h0001, 16'h0001);
    wait_result("div0", 16'hFFFF, OP_DIV, 1'b1, 1'b0);
    wait_result("illegal", 16'h0000, 4'b0010, 1'b1, 1'b1);

    // Backpressure: one in HOLD, four queued, sixth refused.
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      in_valid  = 1'b1;
      in_opcode = OP_ADD;
      in_a      = 16'(k * 256);
      in_b      = 16'(k);
      chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), (k <= 5) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(out_result), 32'h0101);
      chk("stall_pe_a", 32'(pe_a), 32'h0100);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_result($sformatf("drain%0d", k), 16'(k * 16'h0101), OP_ADD, 1'b0, k > 1);
    end
    chk("drain_busy", 32'(busy), 32'd0);
    for (int s = 0; s < 3; s++) begin
      chk("no_sixth", 32'(out_valid), 32'd0);
      step();
    end

    // Reset while in ISSUE with three queued.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(OP_ADD, 16'(k), 16'h0010);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_pe_a", 32'(pe_a), 32'h0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_pe_a", 32'(pe_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    push(OP_ADD, 16'h0001, 16'h0001);
    wait_result("post_rst", 16'h0002, OP_ADD, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      step();
    end
    chk("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
